// File: rtl/tb_reset_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reset_seq
//  Purpose  : Multi-channel reset sequencer for simulation benches. One
//             asynchronous active-high reset fans out to CHANNELS reset
//             outputs that assert immediately and release synchronously to
//             clk, staggered by channel index. A one-cycle req pulse re-runs
//             the release sequence mid-simulation.
//
//  Ports    : clk      in   1         bench clock, single domain
//             rst      in   1         asynchronous active-high reset
//             req      in   1         synchronous pulse, restart sequence
//             rst_out  out  CHANNELS  per-channel active-high reset
//             done     out  1         high once every channel is released
//             busy     out  1         high while the FSM is not in RUN
//
//  Config   : TB_RESET_SEQ_LOG_EN - when defined, prints a message on every
//             channel release and every sequence (re)start, and keeps an
//             internal 32-bit seq_count of sequence starts. Port list and
//             timing are identical either way.
//
//  Revision : 1.0 - initial release
// ============================================================================
module tb_reset_seq #(
  parameter int CHANNELS       = 4,
  parameter int ASSERT_CYCLES  = 32,
  parameter int STAGGER_CYCLES = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int CNT_W          = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req,
  output logic [CHANNELS-1:0] rst_out,
  output logic                done,
  output logic                busy
);

  // Count value at which the last channel releases; the counter must reach it.
  localparam longint LAST_THR = longint'(ASSERT_CYCLES) +
                                longint'(CHANNELS - 1) * longint'(STAGGER_CYCLES);
  localparam longint CNT_MAX  = (64'sd1 <<< CNT_W) - 64'sd1;

`ifndef SYNTHESIS
  if (LAST_THR > CNT_MAX) begin : g_cnt_w_check
    $error("tb_reset_seq: CNT_W=%0d cannot hold %0d", CNT_W, LAST_THR);
  end
`endif

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_HOLD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CNT_W-1:0]      cnt_inc;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CHANNELS-1:0]   rst_out_q, rst_out_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;
  logic [CHANNELS-1:0]   rel_hit;
  logic                  start;

  // --------------------------------------------------------------------------
  // Deassertion synchroniser: async-set to all ones, shifts zeros in once rst
  // drops. The top bit is the synchronised reset.
  // --------------------------------------------------------------------------
  assign sync_d = {sync_q[SYNC_STAGES-2:0], 1'b0};

  assign cnt_inc = cnt_q + CNT_W'(1);

  // Channel i releases when the incremented count reaches its threshold.
  // Comparing against the next count lets the output flop fall on exactly
  // the edge E0 + ASSERT_CYCLES + i*STAGGER_CYCLES.
  for (genvar g = 0; g < CHANNELS; g++) begin : g_rel
    localparam logic [CNT_W-1:0] THR = CNT_W'(ASSERT_CYCLES + g * STAGGER_CYCLES);
    assign rel_hit[g] = (cnt_inc >= THR);
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rst_out_d = rst_out_q;
    done_d    = done_q;
    busy_d    = busy_q;
    start     = 1'b0;

    unique case (state_q)
      ST_WAIT: begin
        // E0 is the edge on which the synchronised reset itself falls.
        // req is deliberately ignored here.
        if (!sync_d[SYNC_STAGES-1]) begin
          start = 1'b1;
        end
      end
      ST_HOLD: begin
        if (req) begin
          start = 1'b1;
        end else begin
          cnt_d     = cnt_inc;
          // Thresholds rise with channel index, so release order is preserved.
          rst_out_d = rst_out_q & ~rel_hit;
          if (rel_hit[CHANNELS-1]) begin
            state_d = ST_RUN;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end
        end
      end
      ST_RUN: begin
        // An unknown req evaluates false here, so X/Z acts as 0.
        if (req) begin
          start = 1'b1;
        end
      end
      default: begin
        state_d = ST_WAIT;
      end
    endcase

    // Every sequence start, wherever it comes from, looks the same.
    if (start) begin
      state_d   = ST_HOLD;
      cnt_d     = '0;
      rst_out_d = '1;
      done_d    = 1'b0;
      busy_d    = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // State and registered outputs. rst forces the reset state with no clock.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_WAIT;
      cnt_q     <= '0;
      sync_q    <= '1;
      rst_out_q <= '1;
      done_q    <= 1'b0;
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sync_q    <= sync_d;
      rst_out_q <= rst_out_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign rst_out = rst_out_q;
  assign done    = done_q;
  assign busy    = busy_q;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst && state_q == ST_RUN && $isunknown(req)) begin
      $warning("%m: req is X/Z while in RUN, treated as 0");
    end
  end
`endif

`ifdef TB_RESET_SEQ_LOG_EN
  logic [31:0] seq_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq_count <= '0;
    end else if (start) begin
      seq_count <= seq_count + 32'd1;
    end
  end

  always @(posedge clk) begin
    if (!rst) begin
      if (start) begin
        $display("-#- %0t | %m: reset sequence (re)started (seq_count=%0d)",
                 $time, seq_count + 32'd1);
      end
      for (int i = 0; i < CHANNELS; i++) begin
        if (rst_out_q[i] && !rst_out_d[i]) begin
          $display("-#- %0t | %m: rst_out[%0d] released", $time, i);
        end
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_tb_reset_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tb_reset_seq
//  Purpose  : Directed self-checking bench for tb_reset_seq. Main instance
//             uses default parameters; two extra instances cover the
//             single-channel and zero-stagger configurations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tb_reset_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req = 1'b0;
  logic       req_off = 1'b0;

  logic [3:0] rst_out;
  logic       done;
  logic       busy;
  logic [0:0] rst_out1;
  logic       done1;
  logic       busy1;
  logic [3:0] rst_out2;
  logic       done2;
  logic       busy2;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  tb_reset_seq dut (
    .clk(clk), .rst(rst), .req(req),
    .rst_out(rst_out), .done(done), .busy(busy)
  );

  tb_reset_seq #(.CHANNELS(1), .ASSERT_CYCLES(1), .STAGGER_CYCLES(0)) dut1 (
    .clk(clk), .rst(rst), .req(req_off),
    .rst_out(rst_out1), .done(done1), .busy(busy1)
  );

  tb_reset_seq #(.CHANNELS(4), .ASSERT_CYCLES(4), .STAGGER_CYCLES(0)) dut2 (
    .clk(clk), .rst(rst), .req(req_off),
    .rst_out(rst_out2), .done(done2), .busy(busy2)
  );

  // Expected state k edges after rst falls: E0 is edge 2, channel i
  // releases at edge 2+32+8i, done at edge 58.
  function automatic logic [3:0] exp_after_rst(int k);
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = (k < 34 + 8 * i);
    return v;
  endfunction

  // Expected state k edges after an E0 caused by req.
  function automatic logic [3:0] exp_after_e0(int k);
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = (k < 32 + 8 * i);
    return v;
  endfunction

  task automatic test_reset();
    @(negedge clk);
    #1;
    tests_run++;
    if (rst_out !== 4'hF || done !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_state: rst_out=%h done=%b busy=%b, want F 0 1", rst_out, done, busy);
    end
    tests_run++;
    if (rst_out1 !== 1'b1 || done1 !== 1'b0 || rst_out2 !== 4'hF || busy2 !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_state_aux: rst_out1=%b done1=%b rst_out2=%h busy2=%b, want 1 0 F 1",
               rst_out1, done1, rst_out2, busy2);
    end
  endtask

  task automatic test_single_and_zero_stagger();
    @(negedge clk);
    rst = 1'b1;
    #20;
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      tests_run++;
      if (rst_out1 !== ((k < 3) ? 1'b1 : 1'b0) || done1 !== ((k >= 3) ? 1'b1 : 1'b0)) begin
        tests_failed++;
        $display("FAIL single_channel edge %0d: rst_out1=%b done1=%b, want %b %b",
                 k, rst_out1, done1, (k < 3), (k >= 3));
      end
      tests_run++;
      if (rst_out2 !== ((k < 6) ? 4'hF : 4'h0) || done2 !== ((k >= 6) ? 1'b1 : 1'b0)) begin
        tests_failed++;
        $display("FAIL zero_stagger edge %0d: rst_out2=%h done2=%b, want %h %b",
                 k, rst_out2, done2, (k < 6) ? 4'hF : 4'h0, (k >= 6));
      end
    end
  endtask

  task automatic test_release_profile();
    @(negedge clk);
    rst = 1'b1;
    #100;
    #3;
    rst = 1'b0;   // falls 2 ns before the next posedge, i.e. async to clk
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      tests_run++;
      if (rst_out !== exp_after_rst(k) || done !== (k >= 58) || busy !== (k < 58)) begin
        tests_failed++;
        $display("FAIL release_profile edge %0d: rst_out=%h done=%b busy=%b, want %h %b %b",
                 k, rst_out, done, busy, exp_after_rst(k), (k >= 58), (k < 58));
      end
    end
  endtask

  task automatic test_req_run();
    @(negedge clk);
    req = 1'b1;
    @(posedge clk);
    #1;
    req = 1'b0;
    tests_run++;
    if (rst_out !== 4'hF || done !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL req_run_e0: rst_out=%h done=%b busy=%b, want F 0 1", rst_out, done, busy);
    end
    for (int k = 1; k <= 57; k++) begin
      @(posedge clk);
      #1;
      tests_run++;
      if (rst_out !== exp_after_e0(k) || done !== (k >= 56) || busy !== (k < 56)) begin
        tests_failed++;
        $display("FAIL req_run edge %0d: rst_out=%h done=%b busy=%b, want %h %b %b",
                 k, rst_out, done, busy, exp_after_e0(k), (k >= 56), (k < 56));
      end
    end
  endtask

  task automatic test_req_hold();
    @(negedge clk);
    req = 1'b1;
    @(posedge clk);
    #1;
    req = 1'b0;
    for (int k = 1; k <= 45; k++) begin
      @(posedge clk);
      #1;
    end
    tests_run++;
    if (rst_out !== 4'hC || busy !== 1'b1 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL req_hold_cnt45: rst_out=%h busy=%b done=%b, want C 1 0", rst_out, busy, done);
    end
    req = 1'b1;   // sampled on the edge where cnt is 45
    @(posedge clk);
    #1;
    req = 1'b0;
    tests_run++;
    if (rst_out !== 4'hF || done !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL req_hold_e0: rst_out=%h done=%b busy=%b, want F 0 1", rst_out, done, busy);
    end
    for (int k = 1; k <= 57; k++) begin
      @(posedge clk);
      #1;
      tests_run++;
      if (rst_out !== exp_after_e0(k) || done !== (k >= 56)) begin
        tests_failed++;
        $display("FAIL req_hold edge %0d: rst_out=%h done=%b, want %h %b",
                 k, rst_out, done, exp_after_e0(k), (k >= 56));
      end
    end
  endtask

  task automatic test_rst_glitch();
    @(negedge clk);
    req = 1'b1;
    @(posedge clk);
    #1;
    req = 1'b0;
    for (int k = 1; k <= 50; k++) begin
      @(posedge clk);
      #1;
    end
    tests_run++;
    if (rst_out !== 4'h8) begin
      tests_failed++;
      $display("FAIL glitch_pre cnt50: rst_out=%h, want 8", rst_out);
    end
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    tests_run++;
    if (rst_out !== 4'hF || busy !== 1'b1 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL glitch_async: rst_out=%h busy=%b done=%b, want F 1 0", rst_out, busy, done);
    end
    #2;
    rst = 1'b0;   // 3 ns pulse, entirely between clock edges
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      tests_run++;
      if (rst_out !== exp_after_rst(k) || done !== (k >= 58) || busy !== (k < 58)) begin
        tests_failed++;
        $display("FAIL glitch_resync edge %0d: rst_out=%h done=%b busy=%b, want %h %b %b",
                 k, rst_out, done, busy, exp_after_rst(k), (k >= 58), (k < 58));
      end
    end
  endtask

  task automatic test_req_x();
    @(negedge clk);
    req = 1'bx;
    @(posedge clk);
    #1;
    req = 1'b0;
    tests_run++;
    if (rst_out !== 4'h0 || done !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL req_x_run: rst_out=%h done=%b busy=%b, want 0 1 0", rst_out, done, busy);
    end
  endtask

  initial begin
    rst = 1'b1;
    req = 1'b0;
    test_reset();
    test_single_and_zero_stagger();
    test_release_profile();
    test_req_run();
    test_req_hold();
    test_rst_glitch();
    test_req_x();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
